// File: rtl/dial_zero_counter_if.sv
// Command stream between a rotation source and the dial engine.
// Standard valid/ready: the source holds every field stable until in_ready is seen.
interface dial_zero_counter_if #(
  parameter int unsigned AMT_W = 10
);
  logic             in_valid;
  logic             in_ready;
  logic             in_dir;
  logic [AMT_W-1:0] in_amt;
  logic             in_last;

  modport master (
    output in_valid,
    output in_dir,
    output in_amt,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_dir,
    input  in_amt,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/dial_zero_counter.sv
// Streaming safe-dial engine: rotates an N-position dial and counts landings on 0
// and every click that reaches 0, reporting one of the two when the run ends.
module dial_zero_counter #(
  parameter int unsigned  DIAL_SIZE = 100,
  parameter int unsigned  START_POS = 50,
  parameter int unsigned  AMT_W     = 10,
  parameter int unsigned  CNT_W     = 32,
  localparam int unsigned POS_W     = $clog2(DIAL_SIZE)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
  dial_zero_counter_if.slave  cmd,
  output logic                busy,
  output logic                finished,
  output logic [POS_W-1:0]    position,
  output logic [CNT_W-1:0]    zero_lands,
  output logic [CNT_W-1:0]    zero_passes,
  output logic [CNT_W-1:0]    result
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StAccept = 3'd1;
  localparam logic [2:0] StReduce = 3'd2;
  localparam logic [2:0] StUpdate = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  typedef logic [POS_W-1:0] pos_t;
  typedef logic [POS_W:0]   sum_t;
  typedef logic [AMT_W-1:0] amt_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam pos_t            StartPos = pos_t'(START_POS);
  localparam sum_t            NSum     = sum_t'(DIAL_SIZE);
  localparam amt_t            NAmt     = amt_t'(DIAL_SIZE);
  localparam longint unsigned AmtSpan  = 64'd1 << AMT_W;
  // When N exceeds every encodable amount the reduce loop never iterates.
  localparam bit              NFitsAmt = longint'(DIAL_SIZE) < AmtSpan;

  logic [2:0] state_q, state_d;
  pos_t       pos_q, pos_d;
  cnt_t       lands_q, lands_d;
  cnt_t       passes_q, passes_d;
  cnt_t       result_q, result_d;
  logic       mode_q, mode_d;
  logic       dir_q, dir_d;
  logic       last_q, last_d;
  amt_t       rem_q, rem_d;
  amt_t       quo_q, quo_d;

  logic rem_ge_n;
  sum_t pos_ext, r_ext, right_sum, right_new, left_new;
  logic right_wrap, left_pass, pass_inc;
  pos_t new_pos;

  assign rem_ge_n = NFitsAmt && (rem_q >= NAmt);

  // In UPDATE rem < N, so the remainder fits the POS_W+1 bit sum width.
  assign pos_ext    = sum_t'(pos_q);
  assign r_ext      = sum_t'(rem_q);
  assign right_sum  = pos_ext + r_ext;
  assign right_wrap = right_sum >= NSum;
  assign right_new  = right_wrap ? right_sum - NSum : right_sum;
  assign left_new   = (pos_ext >= r_ext) ? pos_ext - r_ext : pos_ext + NSum - r_ext;
  assign left_pass  = (pos_q != '0) && (r_ext >= pos_ext);
  assign new_pos    = dir_q ? right_new[POS_W-1:0] : left_new[POS_W-1:0];
  assign pass_inc   = dir_q ? right_wrap : left_pass;

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    lands_d  = lands_q;
    passes_d = passes_q;
    result_d = result_q;
    mode_d   = mode_q;
    dir_d    = dir_q;
    last_d   = last_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          pos_d    = StartPos;
          lands_d  = '0;
          passes_d = '0;
          mode_d   = mode;
          state_d  = StAccept;
        end
      end
      StAccept: begin
        if (cmd.in_valid) begin
          dir_d   = cmd.in_dir;
          last_d  = cmd.in_last;
          rem_d   = cmd.in_amt;
          quo_d   = '0;
          state_d = StReduce;
        end
      end
      StReduce: begin
        if (rem_ge_n) begin
          rem_d = rem_q - NAmt;
          quo_d = quo_q + amt_t'(1);
        end else begin
          state_d = StUpdate;
        end
      end
      StUpdate: begin
        pos_d    = new_pos;
        passes_d = passes_q + cnt_t'(quo_q) + cnt_t'(pass_inc);
        lands_d  = lands_q + cnt_t'(new_pos == '0);
        if (last_q) begin
          result_d = mode_q ? passes_d : lands_d;
          state_d  = StDone;
        end else begin
          state_d  = StAccept;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      pos_q    <= StartPos;
      lands_q  <= '0;
      passes_q <= '0;
      result_q <= '0;
      mode_q   <= 1'b0;
      dir_q    <= 1'b0;
      last_q   <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      lands_q  <= lands_d;
      passes_q <= passes_d;
      result_q <= result_d;
      mode_q   <= mode_d;
      dir_q    <= dir_d;
      last_q   <= last_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
    end
  end

  assign cmd.in_ready = (state_q == StAccept);
  assign busy         = (state_q != StIdle) && (state_q != StDone);
  assign finished     = (state_q == StDone);
  assign position     = pos_q;
  assign zero_lands   = lands_q;
  assign zero_passes  = passes_q;
  assign result       = result_q;

endmodule

// File: tb/tb_dial_zero_counter.sv
// Bench for dial_zero_counter: a click-by-click dial model feeds a scoreboard that a
// monitor drains on every rising finished; two instances cover default and N=7 dials.
module tb_dial_zero_counter;

  localparam int unsigned NA = 100;
  localparam int unsigned SA = 50;
  localparam int unsigned NB = 7;
  localparam int unsigned SB = 3;

  typedef struct packed {
    logic [31:0] pos;
    logic [31:0] lands;
    logic [31:0] passes;
    logic [31:0] result;
  } exp_t;

  typedef struct {
    bit          dir;
    int unsigned amt;
  } cmd_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_a, mode_a, start_b, mode_b;
  logic        busy_a, finished_a, busy_b, finished_b;
  logic [6:0]  position_a;
  logic [2:0]  position_b;
  logic [31:0] lands_a, passes_a, result_a, lands_b, passes_b, result_b;

  dial_zero_counter_if #(.AMT_W(10)) if_a ();
  dial_zero_counter_if #(.AMT_W(10)) if_b ();

  dial_zero_counter #(.DIAL_SIZE(NA), .START_POS(SA), .AMT_W(10), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode_a), .cmd(if_a),
    .busy(busy_a), .finished(finished_a), .position(position_a),
    .zero_lands(lands_a), .zero_passes(passes_a), .result(result_a)
  );

  dial_zero_counter #(.DIAL_SIZE(NB), .START_POS(SB), .AMT_W(10), .CNT_W(32)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mode(mode_b), .cmd(if_b),
    .busy(busy_b), .finished(finished_b), .position(position_b),
    .zero_lands(lands_b), .zero_passes(passes_b), .result(result_b)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t exp_a[$];
  exp_t exp_b[$];
  cmd_t cmds[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: turn the dial one click at a time over the current command list.
  function automatic exp_t model(input int unsigned n, input int unsigned sp, input bit m);
    exp_t        e;
    int unsigned p;
    logic [31:0] lands, passes;
    p      = sp;
    lands  = 0;
    passes = 0;
    foreach (cmds[i]) begin
      for (int k = 0; k < int'(cmds[i].amt); k++) begin
        p = cmds[i].dir ? (p + 1) % n : (p + n - 1) % n;
        if (p == 0) passes++;
      end
      if (p == 0) lands++;
    end
    e.pos    = p;
    e.lands  = lands;
    e.passes = passes;
    e.result = m ? passes : lands;
    return e;
  endfunction

  function automatic void add_cmd(input bit d, input int unsigned amt);
    cmd_t c;
    c.dir = d;
    c.amt = amt;
    cmds.push_back(c);
  endfunction

  function automatic void load_puzzle();
    cmds.delete();
    add_cmd(0, 68); add_cmd(0, 30); add_cmd(1, 48); add_cmd(0, 5);  add_cmd(1, 60);
    add_cmd(0, 55); add_cmd(0, 1);  add_cmd(0, 99); add_cmd(1, 14); add_cmd(0, 82);
  endfunction

  // Called at a negedge; returns just after the consuming posedge.
  task automatic send_a(input bit d, input int unsigned amt, input bit last);
    if_a.in_valid = 1'b1;
    if_a.in_dir   = d;
    if_a.in_amt   = amt[9:0];
    if_a.in_last  = last;
    for (int w = 0; w < 200 && !if_a.in_ready; w++) @(negedge clk);
    chk("hs_ready_a", if_a.in_ready, 1);
    @(posedge clk);
    #1;
    if_a.in_valid = 1'b0;
    if_a.in_amt   = 10'($urandom);
  endtask

  task automatic send_b(input bit d, input int unsigned amt, input bit last);
    if_b.in_valid = 1'b1;
    if_b.in_dir   = d;
    if_b.in_amt   = amt[9:0];
    if_b.in_last  = last;
    for (int w = 0; w < 200 && !if_b.in_ready; w++) @(negedge clk);
    chk("hs_ready_b", if_b.in_ready, 1);
    @(posedge clk);
    #1;
    if_b.in_valid = 1'b0;
  endtask

  task automatic start_run_a(input bit m);
    @(negedge clk);
    start_a = 1'b1;
    mode_a  = m;
    @(negedge clk);
    start_a = 1'b0;
    mode_a  = 1'($urandom);
  endtask

  task automatic wait_fin_a();
    for (int w = 0; w < 20000 && !finished_a; w++) @(negedge clk);
    chk("finish_a", finished_a, 1);
  endtask

  task automatic run_a(input bit m, input int unsigned max_gap);
    exp_a.push_back(model(NA, SA, m));
    start_run_a(m);
    foreach (cmds[i]) begin
      repeat ($urandom_range(max_gap, 0)) @(negedge clk);
      send_a(cmds[i].dir, cmds[i].amt, i == cmds.size() - 1);
      @(negedge clk);
    end
    wait_fin_a();
  endtask

  logic fin_prev_a = 1'b0;
  logic fin_prev_b = 1'b0;
  exp_t e_a, e_b;

  always @(negedge clk) begin
    if (finished_a && !fin_prev_a) begin
      if (exp_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_a: finish with empty scoreboard, got 1, expected 0");
      end else begin
        e_a = exp_a.pop_front();
        chk("position_a", position_a, e_a.pos);
        chk("lands_a", lands_a, e_a.lands);
        chk("passes_a", passes_a, e_a.passes);
        chk("result_a", result_a, e_a.result);
        chk("busy_done_a", busy_a, 0);
      end
    end
    fin_prev_a = finished_a;
  end

  always @(negedge clk) begin
    if (finished_b && !fin_prev_b) begin
      if (exp_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_b: finish with empty scoreboard, got 1, expected 0");
      end else begin
        e_b = exp_b.pop_front();
        chk("position_b", position_b, e_b.pos);
        chk("lands_b", lands_b, e_b.lands);
        chk("passes_b", passes_b, e_b.passes);
        chk("result_b", result_b, e_b.result);
      end
    end
    fin_prev_b = finished_b;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    rst = 1'b1;
    start_a = 1'b0; mode_a = 1'b0; start_b = 1'b0; mode_b = 1'b0;
    if_a.in_valid = 1'b0; if_a.in_dir = 1'b0; if_a.in_amt = '0; if_a.in_last = 1'b0;
    if_b.in_valid = 1'b0; if_b.in_dir = 1'b0; if_b.in_amt = '0; if_b.in_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", if_a.in_ready, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_finished", finished_a, 0);
    chk("rst_position", position_a, SA);
    chk("rst_lands", lands_a, 0);
    chk("rst_passes", passes_a, 0);
    chk("rst_result", result_a, 0);
    chk("rst_position_b", position_b, SB);
    rst = 1'b0;

    // Puzzle example in both modes, the second with source gaps.
    load_puzzle();
    run_a(1'b0, 0);
    load_puzzle();
    run_a(1'b1, 3);
    repeat (5) @(negedge clk);
    chk("fin_held", finished_a, 1);
    chk("result_held", result_a, 6);

    // R1000 reduce timing, then R0 last: finish latency.
    cmds.delete();
    add_cmd(1, 1000); add_cmd(1, 0);
    exp_a.push_back(model(NA, SA, 1'b1));
    start_run_a(1'b1);
    send_a(1, 1000, 0);
    cnt = 0;
    @(negedge clk);
    while (!if_a.in_ready && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk("ready_low_r1000", cnt, 12);
    send_a(1, 0, 1);
    cnt = 0;
    @(negedge clk);
    while (!finished_a && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk("finish_latency", cnt, 2);

    // Zero-amount handling and the pos!=0 guard.
    cmds.delete();
    add_cmd(0, 50); add_cmd(0, 0); add_cmd(1, 0);
    run_a(1'b0, 1);

    // Random runs with random gaps and mode.
    for (int r = 0; r < 8; r++) begin
      cmds.delete();
      for (int i = 0; i < int'($urandom_range(8, 1)); i++)
        add_cmd(1'($urandom), ($urandom_range(3, 0) == 0) ? $urandom_range(1023, 0)
                                                           : $urandom_range(150, 0));
      run_a(1'($urandom), 4);
    end

    // Reset in the middle of the third command's reduce phase.
    cmds.delete();
    start_run_a(1'b0);
    send_a(1, 5, 0);
    @(negedge clk);
    send_a(0, 7, 0);
    @(negedge clk);
    send_a(1, 1000, 0);
    repeat (3) @(negedge clk);
    chk("mid_busy", busy_a, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_position", position_a, SA);
    chk("abort_lands", lands_a, 0);
    chk("abort_passes", passes_a, 0);
    chk("abort_ready", if_a.in_ready, 0);
    chk("abort_finished", finished_a, 0);
    chk("abort_busy", busy_a, 0);
    load_puzzle();
    run_a(1'b1, 2);

    // N=7 instance: start pulsed while busy must be ignored.
    cmds.delete();
    add_cmd(1, 10);
    exp_b.push_back(model(NB, SB, 1'b1));
    @(negedge clk);
    start_b = 1'b1;
    mode_b  = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    send_b(1, 10, 1);
    @(negedge clk);
    start_b = 1'b1;
    mode_b  = 1'b0;
    @(negedge clk);
    start_b = 1'b0;
    for (int w = 0; w < 100 && !finished_b; w++) @(negedge clk);
    chk("finish_b", finished_b, 1);

    repeat (3) @(negedge clk);
    chk("sb_a_empty", exp_a.size(), 0);
    chk("sb_b_empty", exp_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
